fft_result_reorder: RTL

// - Receiving end of the FFT/IFFT core output port (oen/oaddr/oReal/oImag): core

---
 rtl/fft_result_reorder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_result_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_result_reorder                                           |
// | Description : Ping-pong frame buffer behind the FFT/IFFT core output port. |
// |               Bins are written at arbitrary addresses. Frames are read    |
// |               out in natural order on a valid/ready stream.                |
// | Option      : REORDER_DUP_CHECK_EN -- per-bank written bitmap that drives  |
// |               the sticky dup_err flag (tied 0 when undefined).             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_result_reorder #(
  parameter int STAGE      = 8,
  parameter int REAL_WIDTH = 16,
  parameter int IMGN_WIDTH = 16
) (
  input  logic                  iclk,
  input  logic                  rst,
  input  logic                  ien,
  input  logic [STAGE-1:0]      iaddr,
  input  logic [REAL_WIDTH-1:0] iReal,
  input  logic [IMGN_WIDTH-1:0] iImag,
  output logic                  oValid,
  input  logic                  oReady,
  output logic [STAGE-1:0]      oIndex,
  output logic                  oLast,
  output logic [REAL_WIDTH-1:0] oReal,
  output logic [IMGN_WIDTH-1:0] oImag,
  output logic                  ovf,
  output logic                  dup_err
);

  localparam int               c_BINS     = 1 << STAGE;
  localparam int               c_WORD_W   = REAL_WIDTH + IMGN_WIDTH;
  localparam logic [STAGE-1:0] c_LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  // Both banks live in one memory; the bank select is the address MSB.
  logic [c_WORD_W-1:0]   r_ram [0:2*c_BINS-1];

  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic [STAGE-1:0]      r_wr_cnt;
  logic                  r_ovf;

  state_t                r_state;
  logic                  r_rd_bank;
  logic                  r_valid;
  logic                  r_last;
  logic [STAGE-1:0]      r_index;
  logic [REAL_WIDTH-1:0] r_real;
  logic [IMGN_WIDTH-1:0] r_imag;

  logic                  w_free;
  logic                  w_wr_into_freed;
  logic                  w_wr_ok;
  logic                  w_fill;
  logic                  w_rd_bank_ready;
  logic                  w_other_ready;
  logic [STAGE-1:0]      w_rd_idx;
  logic [STAGE:0]        w_rd_addr;
  logic [c_WORD_W-1:0]   w_rd_word;

  // The last beat of a frame is being accepted: its bank is released this cycle.
  assign w_free          = r_valid && oReady && r_last;
  // With both banks full the write bank is the one being drained, so a bin
  // arriving in the release cycle may land in it.
  assign w_wr_into_freed = w_free && (r_rd_bank == r_wr_bank);
  assign w_wr_ok         = ien && (!r_full[r_wr_bank] || w_wr_into_freed);
  assign w_fill          = w_wr_ok && (r_wr_cnt == c_LAST_IDX);
  // Bank readiness includes a fill completing this cycle so the read side
  // starts without waiting for the registered full flag.
  assign w_rd_bank_ready = r_full[r_rd_bank] || (w_fill && (r_wr_bank == r_rd_bank));
  assign w_other_ready   = r_full[~r_rd_bank] || (w_fill && (r_wr_bank != r_rd_bank));

  // FETCH reads index 0; SEND prefetches the following index for the next beat.
  assign w_rd_idx  = (r_state == S_SEND) ? (r_index + STAGE'(1)) : '0;
  assign w_rd_addr = {r_rd_bank, w_rd_idx};
  assign w_rd_word = r_ram[w_rd_addr];

  // Frame memory write port; contents are intentionally not reset.
  always_ff @(posedge iclk) begin
    if (w_wr_ok) begin
      r_ram[{r_wr_bank, iaddr}] <= {iReal, iImag};
    end
  end

  // Write side: bin counting, bank full flags, bank toggling and overflow.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_free) begin
        r_full[r_rd_bank] <= 1'b0;
      end
      if (w_fill) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
        r_wr_cnt          <= '0;
      end else if (w_wr_ok) begin
        r_wr_cnt <= r_wr_cnt + STAGE'(1);
      end
      if (ien && !w_wr_ok) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Read FSM with registered stream outputs, one beat per cycle when ready.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_bank <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_index   <= '0;
      r_real    <= '0;
      r_imag    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_bank_ready) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Frames hold at least two bins, so index 0 is never the last.
          r_valid <= 1'b1;
          r_index <= '0;
          r_last  <= 1'b0;
          r_real  <= w_rd_word[c_WORD_W-1:IMGN_WIDTH];
          r_imag  <= w_rd_word[IMGN_WIDTH-1:0];
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (oReady) begin
            if (r_last) begin
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_rd_bank <= ~r_rd_bank;
              r_state   <= w_other_ready ? S_FETCH : S_IDLE;
            end else begin
              r_index <= w_rd_idx;
              r_last  <= (w_rd_idx == c_LAST_IDX);
              r_real  <= w_rd_word[c_WORD_W-1:IMGN_WIDTH];
              r_imag  <= w_rd_word[IMGN_WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef REORDER_DUP_CHECK_EN
  logic [1:0][c_BINS-1:0] r_written;
  logic                   r_dup;

  // Per-bank written bitmap; a repeated address within a frame flags dup_err.
  // A bank released this cycle counts as empty for the check.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_written <= '0;
      r_dup     <= 1'b0;
    end else begin
      if (w_free) begin
        r_written[r_rd_bank] <= '0;
      end
      if (w_wr_ok) begin
        r_written[r_wr_bank][iaddr] <= 1'b1;
        if (r_written[r_wr_bank][iaddr] && !w_wr_into_freed) begin
          r_dup <= 1'b1;
        end
      end
    end
  end

  assign dup_err = r_dup;
`else
  assign dup_err = 1'b0;
`endif

  assign oValid = r_valid;
  assign oIndex = r_index;
  assign oLast  = r_last;
  assign oReal  = r_real;
  assign oImag  = r_imag;
  assign ovf    = r_ovf;

endmodule
`default_nettype wire
